// File: rtl/blk_8f40f0.sv
// IJTAG segment-insertion-bit array: one SIB per child segment.
// Ports: ijtag_tck/ijtag_reset (sync, active-high); ijtag_sel/si/ce/se/ue
//   network controls; ijtag_from_so/seg_status per-child inputs; ijtag_so
//   scan out; ijtag_to_* child scan-in, select and broadcast controls;
//   seg_open (update shadow) and onehot_err (sticky multi-open flag).
module blk_8f40f0 #(
    parameter int NUM_SEG        = 4,
    parameter int CAPTURE_STATUS = 0,
    parameter int ONE_HOT        = 0
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               ijtag_sel,
    input  logic               ijtag_si,
    input  logic               ijtag_ce,
    input  logic               ijtag_se,
    input  logic               ijtag_ue,
    input  logic [NUM_SEG-1:0] ijtag_from_so,
    input  logic [NUM_SEG-1:0] seg_status,
    output logic               ijtag_so,
    output logic [NUM_SEG-1:0] ijtag_to_si,
    output logic [NUM_SEG-1:0] ijtag_to_sel,
    output logic               ijtag_to_ce,
    output logic               ijtag_to_se,
    output logic               ijtag_to_ue,
    output logic               ijtag_to_reset,
    output logic [NUM_SEG-1:0] seg_open,
    output logic               onehot_err
);

    logic [NUM_SEG-1:0] sib_q, sib_d;
    logic [NUM_SEG-1:0] sib_upd_q, sib_upd_d;
    logic [NUM_SEG-1:0] to_en_q, to_en_d;
    logic               onehot_err_q, onehot_err_d;

    logic [NUM_SEG-1:0] to_si;
    logic [NUM_SEG-1:0] shift_src;
    logic [NUM_SEG-1:0] cap_src;
    logic [NUM_SEG-1:0] low_bit;
    logic               multi_open;

    // Each SIB feeds the next; an open segment splices its child chain in
    // front of its own SIB, a closed one bypasses the child entirely.
    always_comb begin
        to_si[0] = ijtag_si;
        for (int k = 1; k < NUM_SEG; k++) begin
            to_si[k] = sib_q[k-1];
        end
        for (int k = 0; k < NUM_SEG; k++) begin
            shift_src[k] = sib_upd_q[k] ? ijtag_from_so[k] : to_si[k];
        end
    end

    assign cap_src = (CAPTURE_STATUS != 0) ? seg_status : '0;

    // Two's-complement trick isolates the lowest set bit.
    assign low_bit    = sib_q & (-sib_q);
    assign multi_open = (sib_q & (sib_q - NUM_SEG'(1))) != '0;

    always_comb begin
        sib_d        = sib_q;
        sib_upd_d    = sib_upd_q;
        to_en_d      = sib_upd_q;
        onehot_err_d = onehot_err_q;
        if (ijtag_reset) begin
            sib_d        = '0;
            sib_upd_d    = '0;
            to_en_d      = '0;
            onehot_err_d = 1'b0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                sib_d = cap_src;
            end else if (ijtag_se) begin
                sib_d = shift_src;
            end
            // Update samples the pre-edge SIBs, so a same-edge shift or
            // capture does not leak into the shadow.
            if (ijtag_ue) begin
                if ((ONE_HOT != 0) && multi_open) begin
                    sib_upd_d    = low_bit;
                    onehot_err_d = 1'b1;
                end else begin
                    sib_upd_d = sib_q;
                end
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        sib_q        <= sib_d;
        sib_upd_q    <= sib_upd_d;
        to_en_q      <= to_en_d;
        onehot_err_q <= onehot_err_d;
    end

    assign ijtag_to_si    = to_si;
    assign ijtag_so       = sib_q[NUM_SEG-1];
    assign ijtag_to_sel   = to_en_q & {NUM_SEG{ijtag_sel}};
    assign ijtag_to_ce    = ijtag_ce;
    assign ijtag_to_se    = ijtag_se;
    assign ijtag_to_ue    = ijtag_ue;
    assign ijtag_to_reset = ijtag_reset;
    assign seg_open       = sib_upd_q;
    assign onehot_err     = (ONE_HOT != 0) ? onehot_err_q : 1'b0;

endmodule

// File: doc/blk_8f40f0.md
MEMLIBC_MEMORY_BIST_ASSEMBLY_RTL_TESSENT_SIB_ARRAY -- requirements
Module: memlibc_memory_bist_assembly_rtl_tessent_sib_array

Interface
REQ-001 SHALL have parameters:
  - NUM_SEG, default 4, number of child segments (1..16).
  - CAPTURE_STATUS, default 0, 1 = capture loads seg_status.
  - ONE_HOT, default 0, 1 = at most one segment open.
REQ-002 SHALL have ports (name, direction, width, meaning):
  - ijtag_tck, in, 1, sole clock; all state on its rising edge.
  - ijtag_reset, in, 1, synchronous reset, active-high.
  - ijtag_sel, in, 1, network select.
  - ijtag_si, in, 1, scan in.
  - ijtag_ce, in, 1, capture enable.
  - ijtag_se, in, 1, shift enable.
  - ijtag_ue, in, 1, update enable.
  - ijtag_from_so, in, NUM_SEG, child segment scan outs.
  - seg_status, in, NUM_SEG, per-segment status for capture.
  - ijtag_so, out, 1, scan out.
  - ijtag_to_si, out, NUM_SEG, child scan ins.
  - ijtag_to_sel, out, NUM_SEG, child selects.
  - ijtag_to_ce, ijtag_to_se, ijtag_to_ue, ijtag_to_reset, out, 1 each, broadcast to children.
  - seg_open, out, NUM_SEG, update-shadow state.
  - onehot_err, out, 1, sticky multi-open violation.

Function
REQ-003 SHALL hold shift bits sib[NUM_SEG-1:0], shadow sib_upd[NUM_SEG-1:0], delayed enables to_en[NUM_SEG-1:0], and onehot_err, all flops.
REQ-004 SHALL drive ijtag_to_si[0]=ijtag_si and ijtag_to_si[k]=sib[k-1] for k>0, combinationally.
REQ-005 SHALL drive ijtag_so=sib[NUM_SEG-1] directly from the flop, with no retiming stage.
REQ-006 SHALL load sib[k] from ijtag_from_so[k] on shift when sib_upd[k]=1, else from ijtag_to_si[k].
REQ-007 SHALL apply sib priority as: reset > (ce & sel) > (se & sel) > hold.
REQ-008 SHALL load sib[k] on capture with seg_status[k] when CAPTURE_STATUS=1, else with 0.
REQ-009 SHALL set sib_upd <= sib on (ue & sel), using the pre-edge sib value, independent of ce/se on the same edge.
REQ-010 SHALL, when ONE_HOT=1 and the update source has more than one bit set, load only the lowest-index set bit into sib_upd and set onehot_err.
REQ-011 SHALL hold onehot_err at 1 until ijtag_reset; ONE_HOT=0 SHALL tie onehot_err to 0.
REQ-012 SHALL register to_en <= sib_upd every cycle, a one-cycle lag after update.
REQ-013 SHALL drive ijtag_to_sel[k]=to_en[k] & ijtag_sel combinationally.
REQ-014 SHALL drive seg_open=sib_upd.
REQ-015 SHALL pass ijtag_ce, ijtag_se, ijtag_ue and ijtag_reset unmodified to ijtag_to_ce, ijtag_to_se, ijtag_to_ue and ijtag_to_reset.
REQ-016 SHALL ignore ce, se and ue when ijtag_sel=0; sib and sib_upd hold.
REQ-017 SHALL give the scan path length NUM_SEG plus the sum of open child lengths.
REQ-018 SHALL never let a closed segment's ijtag_from_so reach ijtag_so.

Reset
REQ-019 SHALL clear sib, sib_upd, to_en and onehot_err on the first rising edge with ijtag_reset=1, overriding any ce/se/ue.
REQ-020 SHALL hold ijtag_so=0, ijtag_to_sel=0, seg_open=0 and onehot_err=0 after that edge and while ijtag_reset stays high.
REQ-021 SHALL abort any shift in progress on a mid-shift reset, with no partial update.

Verification (NUM_SEG=4)
REQ-022 SHALL cover open-segment: reset, sel=1, shift si 0,0,0,1, ue one cycle -> seg_open=0001; ijtag_to_sel=0001 one edge after the update edge.
REQ-023 SHALL cover path length: seg0 open with a 3-flop child, shift a single 1 -> ijtag_so=1 after exactly 7 shift edges.
REQ-024 SHALL cover status capture: CAPTURE_STATUS=1, seg_status=1010, ce, then 4 shifts -> ijtag_so sequence 1,0,1,0.
REQ-025 SHALL cover one-hot enforcement: ONE_HOT=1, sib=0110, ue -> seg_open=0010, onehot_err=1, still 1 after a later legal update.
REQ-026 SHALL cover mid-shift reset: reset high mid-shift with seg_open=0011 -> next edge all state 0, ijtag_to_sel=0000.
REQ-027 SHALL cover deselect: sel=0 with ce, se and ue pulsed -> sib, seg_open and ijtag_so unchanged.
